// File: rtl/flash_dspi_pkg.sv
// Shared definitions for the dual-IO SPI flash responder.
//   - command codes and the continuous-mode marker value
//   - FSM state encoding
//   - phase lengths in bus cycles, and a helper that turns a length
//     into the terminal count of the 5-bit phase-cycle counter
package flash_dspi_pkg;

   localparam logic [7:0] CMD_RD_DIO     = 8'hBB;
   localparam logic [7:0] CMD_MODE_RESET = 8'hFF;
   localparam logic [1:0] M_CONT         = 2'b10;

   localparam int CMD_LEN  = 8;
   localparam int ADDR_LEN = 12;
   localparam int MODE_LEN = 4;
   localparam int BYTE_LEN = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_MODE   = 3'd3,
      ST_DATA   = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

   function automatic logic [4:0] last_cnt(input int len);
      return 5'(len - 1);
   endfunction

endpackage

// File: rtl/flash_dspi_responder.sv
// Flash-side responder for the "fast read dual IO" (0xBB) command with
// continuous read mode. Streams bytes from an external synchronous memory
// with one cycle of read latency.
//
// Ports
//   clk        bus/SPI bit clock
//   resetn     asynchronous active-low reset
//   mspi_cs    chip select, active low, sampled on clk rising edge
//   io_in      {IO1, IO0} pin values
//   io_out     {IO1, IO0} drive values
//   io_oe      per-bit output enable (tri-state resolved outside)
//   mem_rd     one-cycle memory read strobe
//   mem_addr   byte address, valid while mem_rd is high
//   mem_data   read data, valid the cycle after mem_rd
//   cont_mode  continuous read mode flag
//   busy       transaction in progress
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | deselected; next selected edge starts CMD or ADDR
// ST_CMD    | receiving the 8-bit command on IO0
// ST_ADDR   | receiving 24 address bits, two per cycle
// ST_MODE   | receiving the 8 mode bits M[7:0]
// ST_DATA   | driving read data, two bits per cycle, unbounded
// ST_IGNORE | unsupported command; silent until deselect
module flash_dspi_responder #(
   parameter logic [7:0] CMD_RD_DIO = flash_dspi_pkg::CMD_RD_DIO,
   parameter logic [1:0] M_CONT     = flash_dspi_pkg::M_CONT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mspi_cs,
   input  logic [1:0]  io_in,
   output logic [1:0]  io_out,
   output logic [1:0]  io_oe,
   output logic        mem_rd,
   output logic [23:0] mem_addr,
   input  logic [7:0]  mem_data,
   output logic        cont_mode,
   output logic        busy
);

   import flash_dspi_pkg::*;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;

   // The IDLE edge already carries bus cycle 0, so it is processed as the
   // first cycle of whichever phase the transaction opens with.
   state_t      phase;
   logic [4:0]  phase_cnt;
   logic        phase_last;

   logic [21:0] in_sr_q;
   logic [23:0] in_next;
   logic [7:0]  dsr_q;
   logic [7:0]  pre_byte_q;
   logic        rd_pend_q;
   logic [1:0]  io_out_q;
   logic [1:0]  io_oe_q;
   logic        mem_rd_q;
   logic [23:0] mem_addr_q;
   logic        cont_mode_q;

   always_comb begin
      phase     = state_q;
      phase_cnt = cnt_q;
      if (state_q == ST_IDLE) begin
         phase     = cont_mode_q ? ST_ADDR : ST_CMD;
         phase_cnt = '0;
      end

      case (phase)
         ST_CMD:  phase_last = (phase_cnt == last_cnt(CMD_LEN));
         ST_ADDR: phase_last = (phase_cnt == last_cnt(ADDR_LEN));
         ST_MODE: phase_last = (phase_cnt == last_cnt(MODE_LEN));
         ST_DATA: phase_last = (phase_cnt == last_cnt(BYTE_LEN));
         default: phase_last = 1'b0;
      endcase

      // Command bits arrive one per cycle on IO0, everything else two per cycle.
      if (phase == ST_CMD) begin
         in_next = {16'h0000, in_sr_q[6:0], io_in[0]};
      end else begin
         in_next = {in_sr_q, io_in};
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mspi_cs) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         state_d = phase;
         cnt_d   = phase_cnt + 5'd1;
         case (phase)
            ST_CMD: begin
               if (phase_last) begin
                  cnt_d   = '0;
                  state_d = (in_next[7:0] == CMD_RD_DIO) ? ST_ADDR : ST_IGNORE;
               end
            end
            ST_ADDR: begin
               if (phase_last) begin
                  cnt_d   = '0;
                  state_d = ST_MODE;
               end
            end
            ST_MODE: begin
               if (phase_last) begin
                  cnt_d   = '0;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (phase_last) begin
                  cnt_d = '0;
               end
            end
            ST_IGNORE: cnt_d = '0;
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Datapath and registered pin/memory outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_sr_q     <= '0;
         dsr_q       <= '0;
         pre_byte_q  <= '0;
         rd_pend_q   <= 1'b0;
         io_out_q    <= '0;
         io_oe_q     <= '0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         cont_mode_q <= 1'b0;
      end else begin
         mem_rd_q  <= 1'b0;
         rd_pend_q <= mem_rd_q;
         if (rd_pend_q) begin
            pre_byte_q <= mem_data;
         end

         if (mspi_cs) begin
            io_oe_q   <= '0;
            io_out_q  <= '0;
            rd_pend_q <= 1'b0;
            // Only a completed MODE phase may keep continuous mode alive;
            // this is what makes the all-ones mode reset work.
            if (state_q != ST_IDLE && state_q != ST_DATA) begin
               cont_mode_q <= 1'b0;
            end
         end else begin
            if (phase != ST_DATA) begin
               in_sr_q <= in_next[21:0];
            end
            case (phase)
               ST_ADDR: begin
                  io_oe_q  <= '0;
                  io_out_q <= '0;
                  if (phase_last) begin
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= in_next;
                  end
               end
               ST_MODE: begin
                  if (phase_last) begin
                     cont_mode_q <= (in_next[5:4] == M_CONT);
                     io_oe_q     <= 2'b11;
                     io_out_q    <= pre_byte_q[7:6];
                     dsr_q       <= {pre_byte_q[5:0], 2'b00};
                     mem_rd_q    <= 1'b1;
                     mem_addr_q  <= mem_addr_q + 24'd1;
                  end
               end
               ST_DATA: begin
                  io_oe_q <= 2'b11;
                  if (phase_last) begin
                     io_out_q   <= pre_byte_q[7:6];
                     dsr_q      <= {pre_byte_q[5:0], 2'b00};
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= mem_addr_q + 24'd1;
                  end else begin
                     io_out_q <= dsr_q[7:6];
                     dsr_q    <= {dsr_q[5:0], 2'b00};
                  end
               end
               default: begin
                  io_oe_q  <= '0;
                  io_out_q <= '0;
               end
            endcase
         end
      end
   end

   // Output logic
   always_comb begin
      busy      = (state_q != ST_IDLE);
      io_out    = io_out_q;
      io_oe     = io_oe_q;
      mem_rd    = mem_rd_q;
      mem_addr  = mem_addr_q;
      cont_mode = cont_mode_q;
   end

endmodule

// File: tb/tb_flash_dspi_responder.sv
// Directed bench for flash_dspi_responder with a 1-cycle-latency ROM.
module tb_flash_dspi_responder;

   logic        clk;
   logic        resetn;
   logic        mspi_cs;
   logic [1:0]  io_in;
   logic [1:0]  io_out;
   logic [1:0]  io_oe;
   logic        mem_rd;
   logic [23:0] mem_addr;
   logic [7:0]  mem_data;
   logic        cont_mode;
   logic        busy;

   flash_dspi_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .mspi_cs   (mspi_cs),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oe     (io_oe),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .cont_mode (cont_mode),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: a[7:0]^a[15:8]^a[23:16]^0x87 (0x000123 -> 0xA5).
   function automatic logic [7:0] rom_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
   endfunction

   // Data is only presented in the single cycle after the strobe.
   logic [7:0] rom_q;
   always @(posedge clk) rom_q <= mem_rd ? rom_byte(mem_addr) : 8'h00;
   assign mem_data = rom_q;

   int   rd_b2b = 0;
   logic rd_prev = 1'b0;
   always @(posedge clk) begin
      if (mem_rd && rd_prev) rd_b2b++;
      rd_prev <= mem_rd;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs observed during the cycle whose inputs are being driven.
   logic [1:0]  o_oe, o_out;
   logic        o_rd, o_cont, o_busy;
   logic [23:0] o_addr;

   task automatic cyc(input logic cs, input logic [1:0] io);
      @(negedge clk);
      o_oe   = io_oe;
      o_out  = io_out;
      o_rd   = mem_rd;
      o_addr = mem_addr;
      o_cont = cont_mode;
      o_busy = busy;
      mspi_cs = cs;
      io_in   = io;
   endtask

   task automatic deselect(input string name);
      cyc(1'b1, 2'b00);
      cyc(1'b1, 2'b00);
      check({name, "_desel_oe"}, 32'(o_oe), 32'd0);
      check({name, "_desel_busy"}, 32'(o_busy), 32'd0);
   endtask

   task automatic send_cmd(input logic [7:0] c, output int oe_bad);
      oe_bad = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, {1'b0, c[7-i]});
         if (o_oe != 2'b00 || o_rd) oe_bad++;
      end
   endtask

   typedef struct {
      bit          use_cmd;
      logic [23:0] addr;
      logic [7:0]  mode;
      int          nbytes;
      logic [7:0]  b0, b1, b2;
      bit          exp_cont;
   } vec_t;

   task automatic run_txn(input string name, input vec_t v);
      int          bad;
      int          tmp;
      logic [23:0] a;
      logic [7:0]  got, exp_b;
      bad = 0;
      if (v.use_cmd) begin
         send_cmd(8'hBB, tmp);
         bad += tmp;
      end
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, v.addr[(23-2*i) -: 2]);
         if (o_oe != 2'b00) bad++;
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, v.mode[(7-2*i) -: 2]);
         if (o_oe != 2'b00) bad++;
         if (i == 0) begin
            check({name, "_rd_addr_strobe"}, 32'(o_rd), 32'd1);
            check({name, "_rd_addr"}, 32'(o_addr), 32'(v.addr));
         end
      end
      check({name, "_oe_low_before_data"}, 32'(bad), 32'd0);
      a = v.addr;
      bad = 0;
      for (int j = 0; j < v.nbytes; j++) begin
         got = '0;
         for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 2'b00);
            if (o_oe != 2'b11) bad++;
            got = {got[5:0], o_out};
            if (c == 0) begin
               a = a + 24'd1;
               check({name, "_next_rd"}, 32'(o_rd), 32'd1);
               check({name, "_next_addr"}, 32'(o_addr), 32'(a));
               if (j == 0) check({name, "_cont_mode"}, 32'(o_cont), 32'(v.exp_cont));
            end
         end
         case (j)
            0:       exp_b = v.b0;
            1:       exp_b = v.b1;
            default: exp_b = v.b2;
         endcase
         check($sformatf("%s_byte%0d", name, j), 32'(got), 32'(exp_b));
      end
      check({name, "_oe_in_data"}, 32'(bad), 32'd0);
      deselect(name);
   endtask

   vec_t vecs[6];

   initial begin
      int          bad;
      int          tmp;
      logic [23:0] aa;

      resetn  = 1'b0;
      mspi_cs = 1'b1;
      io_in   = 2'b00;
      #1;
      check("rst_io_oe", 32'(io_oe), 32'd0);
      check("rst_io_out", 32'(io_out), 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_cont_mode", 32'(cont_mode), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      cyc(1'b1, 2'b00);

      // 16 ones on IO0: mode reset, decoded as command 0xFF -> ignored
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 2'b01);
         if (o_oe != 2'b00 || o_rd) bad++;
         if (i == 1) check("mrst_busy_rise", 32'(o_busy), 32'd1);
      end
      check("mrst_quiet", 32'(bad), 32'd0);
      deselect("mrst");
      check("mrst_cont", 32'(o_cont), 32'd0);

      vecs[0] = '{1'b1, 24'h000123, 8'h20, 2, 8'hA5, 8'hA2, 8'h00, 1'b1};
      vecs[1] = '{1'b0, 24'h123456, 8'h20, 1, 8'hF7, 8'h00, 8'h00, 1'b1};
      vecs[2] = '{1'b0, 24'hFFFFFE, 8'h20, 3, 8'h79, 8'h78, 8'h87, 1'b1};
      vecs[3] = '{1'b0, 24'h000123, 8'h00, 1, 8'hA5, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{1'b1, 24'h123456, 8'hA5, 1, 8'hF7, 8'h00, 8'h00, 1'b1};
      vecs[5] = '{1'b0, 24'hFFFFFF, 8'h10, 2, 8'h78, 8'h87, 8'h00, 1'b0};
      for (int k = 0; k < 6; k++) run_txn($sformatf("vec%0d", k), vecs[k]);

      // Continuous mode left: address bits of 0x123456 decode as command 0x46
      bad = 0;
      aa = 24'h123456;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, aa[(23-2*i) -: 2]);
         if (o_oe != 2'b00 || o_rd) bad++;
      end
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 2'b10);
         if (o_oe != 2'b00 || o_rd) bad++;
      end
      check("nocont_ignored", 32'(bad), 32'd0);
      check("nocont_busy", 32'(o_busy), 32'd1);
      deselect("nocont");

      // Unknown command 0x03, then a normal read
      send_cmd(8'h03, bad);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 2'b11);
         if (o_oe != 2'b00 || o_rd || !o_busy) bad++;
      end
      check("unk_ignored", 32'(bad), 32'd0);
      deselect("unk");
      run_txn("after_unk", '{1'b1, 24'h000124, 8'h20, 1, 8'hA2, 8'h00, 8'h00, 1'b1});

      // Abort at cycle 10 of a continuous-mode transaction
      for (int i = 0; i < 10; i++) cyc(1'b0, aa[(23-2*i) -: 2]);
      deselect("abort");
      check("abort_cont", 32'(o_cont), 32'd0);
      run_txn("after_abort", '{1'b1, 24'h000123, 8'h20, 1, 8'hA5, 8'h00, 8'h00, 1'b1});

      // Reset pulse in the middle of DATA (continuous transaction)
      aa = 24'h000124;
      for (int i = 0; i < 12; i++) cyc(1'b0, aa[(23-2*i) -: 2]);
      for (int i = 0; i < 4; i++) cyc(1'b0, (i == 1) ? 2'b10 : 2'b00);
      cyc(1'b0, 2'b00);
      cyc(1'b0, 2'b00);
      check("prerst_oe", 32'(o_oe), 32'd3);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("midrst_io_oe", 32'(io_oe), 32'd0);
      check("midrst_io_out", 32'(io_out), 32'd0);
      check("midrst_cont", 32'(cont_mode), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_mem_rd", 32'(mem_rd), 32'd0);
      mspi_cs = 1'b1;
      #2;
      resetn = 1'b1;
      deselect("postrst");
      run_txn("after_rst", '{1'b1, 24'h000124, 8'h00, 1, 8'hA2, 8'h00, 8'h00, 1'b0});

      check("mem_rd_back_to_back", 32'(rd_b2b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
